decoder_scan_n: RTL



---
 rtl/decoder_scan_pkg.sv | 14 +
 rtl/decoder_scan_n_prescaler.sv | 31 +++
 rtl/decoder_scan_n.sv | 111 +++++++++++
 3 files changed

// File: rtl/decoder_scan_pkg.sv
// Shared types and helpers for the decoder_scan_n block.
package decoder_scan_pkg;

    typedef enum logic [1:0] {IDLE, DIRECT, SCAN} dec_state_t;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // Prescaler counter width: clog2 of the divide ratio, never narrower than one bit.
    function automatic int unsigned presc_width(input int unsigned div);
        return (div <= 2) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/decoder_scan_n_prescaler.sv
// Scan prescaler: counts 0..TICK_DIV-1 while run is high and flags the terminal count.
module scan_prescaler
    import decoder_scan_pkg::*;
#(
    parameter int unsigned TICK_DIV = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CW = presc_width(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = run && (cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (run) begin
            cnt <= tick ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/decoder_scan_n.sv
// Registered binary decoder with DIRECT and free-running SCAN modes.
// Define DECODER_SCAN_THERMO_EN to add the `thermo` input (thermometer-coded out).
module decoder_scan_n
    import decoder_scan_pkg::*;
#(
    parameter int unsigned SEL_W     = 4,
    parameter int unsigned TICK_DIV  = 1000,
    parameter int unsigned SCAN_LAST = 2**SEL_W - 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ena,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      a,
`ifdef DECODER_SCAN_THERMO_EN
    input  logic                  thermo,
`endif
    output logic [2**SEL_W-1:0]   out,
    output logic [SEL_W-1:0]      idx,
    output logic                  step,
    output logic                  active
);

    localparam int unsigned OUT_W = 2**SEL_W;
    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(SCAN_LAST);

    if (SCAN_LAST > OUT_W - 1) begin : g_bad_scan_last
        $error("decoder_scan_n: SCAN_LAST %0d exceeds 2**SEL_W-1", SCAN_LAST);
    end
    if (TICK_DIV < 1) begin : g_bad_tick_div
        $error("decoder_scan_n: TICK_DIV must be at least 1");
    end

    dec_state_t       state;
    logic [SEL_W-1:0] scan_idx;
    logic [SEL_W-1:0] scan_idx_d;
    logic             scan_req;
    logic             run;
    logic             clear;
    logic             tick;
    logic             thermo_en;

`ifdef DECODER_SCAN_THERMO_EN
    assign thermo_en = thermo;
`else
    assign thermo_en = 1'b0;
`endif

    // Only an edge already in SCAN counts; entry edges (from IDLE or DIRECT) leave the
    // prescaler alone, and entry from DIRECT additionally restarts the scan.
    assign scan_req = ena && (mode == MODE_SCAN);
    assign run      = scan_req && (state == SCAN);
    assign clear    = scan_req && (state == DIRECT);

    scan_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk   (clk),
        .rst   (rst),
        .run   (run),
        .clear (clear),
        .tick  (tick)
    );

    always_comb begin
        scan_idx_d = scan_idx;
        if (clear) begin
            scan_idx_d = '0;
        end else if (tick) begin
            scan_idx_d = (scan_idx == LAST_IDX) ? '0 : scan_idx + 1'b1;
        end
    end

    function automatic logic [OUT_W-1:0] decode(input logic [SEL_W-1:0] sel, input logic therm);
        logic [OUT_W-1:0] d;
        for (int i = 0; i < OUT_W; i++) begin
            d[i] = therm ? (SEL_W'(i) <= sel) : (SEL_W'(i) == sel);
        end
        return d;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            scan_idx <= '0;
            idx      <= '0;
            out      <= '0;
            step     <= 1'b0;
            active   <= 1'b0;
        end else begin
            scan_idx <= scan_idx_d;
            step     <= tick;
            if (!ena) begin
                state  <= IDLE;
                out    <= '0;
                active <= 1'b0;
            end else if (mode == MODE_DIRECT) begin
                state  <= DIRECT;
                idx    <= a;
                out    <= decode(a, thermo_en);
                active <= 1'b1;
            end else begin
                state  <= SCAN;
                idx    <= scan_idx_d;
                out    <= decode(scan_idx_d, thermo_en);
                active <= 1'b1;
            end
        end
    end

endmodule
